// File: rtl/booth_pkg.sv
// Shared constants and types for the Booth multiplier controller.
// Control-word bit indices, control width and the FSM state enum.
package booth_pkg;

    localparam int CTL_W    = 11;

    localparam int CTL_LDA  = 0;
    localparam int CTL_LDQ  = 1;
    localparam int CTL_LDM  = 2;
    localparam int CTL_QM1  = 3;
    localparam int CTL_SUB  = 4;
    localparam int CTL_SHR  = 7;
    localparam int CTL_CNT  = 8;
    localparam int CTL_OUTA = 9;
    localparam int CTL_OUTQ = 10;

    localparam logic [2:0] CNT_LAST = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        LOAD_M,
        LOAD_Q,
        EVAL,
        SHIFT,
        OUT_A,
        OUT_Q
    } booth_state_t;

    // One-hot control word with a single bit set.
    function automatic logic [CTL_W-1:0] ctl_bit(input int idx);
        logic [CTL_W-1:0] w;
        w = '0;
        w[idx] = 1'b1;
        return w;
    endfunction

endpackage

// File: rtl/booth_controller.sv
// Sequencing FSM for the 8-bit radix-2 Booth multiplier datapath.
// Ports: clk, reset (async, active-high), start, q0, q_1, count[2:0],
//   out_ready in; control[10:0], dp_clr, opnd_sel, busy, out_valid,
//   out_hi, done out. dp_clr and done come straight from flops.
module booth_controller
    import booth_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             q0,
    input  logic             q_1,
    input  logic [2:0]       count,
    input  logic             out_ready,
    output logic [CTL_W-1:0] control,
    output logic             dp_clr,
    output logic             opnd_sel,
    output logic             busy,
    output logic             out_valid,
    output logic             out_hi,
    output logic             done
);

    booth_state_t state;

    // dp_clr feeds the datapath's async reset, so it must be glitch-free:
    // it is registered on the IDLE->CLEAR edge and dropped on the next.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            dp_clr <= 1'b0;
            done   <= 1'b0;
        end else begin
            dp_clr <= 1'b0;
            done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        state  <= CLEAR;
                        dp_clr <= 1'b1;
                    end
                end
                CLEAR:  state <= LOAD_M;
                LOAD_M: state <= LOAD_Q;
                LOAD_Q: state <= EVAL;
                EVAL: begin
                    // Add/sub pairs need a separate shift cycle;
                    // shift-only pairs shift in place.
                    if (q0 ^ q_1)
                        state <= SHIFT;
                    else if (count == CNT_LAST)
                        state <= OUT_A;
                end
                SHIFT: begin
                    if (count == CNT_LAST)
                        state <= OUT_A;
                    else
                        state <= EVAL;
                end
                OUT_A: begin
                    if (out_ready)
                        state <= OUT_Q;
                end
                OUT_Q: begin
                    if (out_ready) begin
                        state <= IDLE;
                        done  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);

    // Decoded from state; EVAL also looks at q0/q_1.
    always_comb begin
        control   = '0;
        opnd_sel  = 1'b0;
        out_valid = 1'b0;
        out_hi    = 1'b0;
        unique case (state)
            IDLE, CLEAR: ;
            LOAD_M: begin
                control  = ctl_bit(CTL_LDM);
                opnd_sel = 1'b0;
            end
            LOAD_Q: begin
                control  = ctl_bit(CTL_LDQ);
                opnd_sel = 1'b1;
            end
            EVAL: begin
                unique case ({q0, q_1})
                    2'b10:
                        control = ctl_bit(CTL_LDA)
                                | ctl_bit(CTL_SUB);
                    2'b01:
                        control = ctl_bit(CTL_LDA);
                    default:
                        control = ctl_bit(CTL_SHR)
                                | ctl_bit(CTL_CNT);
                endcase
            end
            SHIFT: begin
                control = ctl_bit(CTL_SHR)
                        | ctl_bit(CTL_CNT);
            end
            OUT_A: begin
                control   = ctl_bit(CTL_OUTA);
                out_valid = 1'b1;
                out_hi    = 1'b1;
            end
            OUT_Q: begin
                control   = ctl_bit(CTL_OUTQ);
                out_valid = 1'b1;
                out_hi    = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_booth_controller.sv
// Self-checking bench for booth_controller with a behavioural datapath.
// Table of multiplies plus back-pressure and mid-operation reset checks.
module tb_booth_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        out_ready;
    logic [10:0] control;
    logic        dp_clr;
    logic        opnd_sel;
    logic        busy;
    logic        out_valid;
    logic        out_hi;
    logic        done;

    // datapath model state
    logic [7:0] ra, rq, rm;
    logic       qm1;
    logic [2:0] cnt;
    logic [7:0] mm, mq;
    logic [7:0] inbus, outbus;
    logic       dp_rst;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    booth_controller dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .q0        (rq[0]),
        .q_1       (qm1),
        .count     (cnt),
        .out_ready (out_ready),
        .control   (control),
        .dp_clr    (dp_clr),
        .opnd_sel  (opnd_sel),
        .busy      (busy),
        .out_valid (out_valid),
        .out_hi    (out_hi),
        .done      (done)
    );

    assign dp_rst = reset | dp_clr;
    assign inbus  = opnd_sel ? mq : mm;
    assign outbus = control[9]  ? ra :
                    control[10] ? rq : 8'h00;

    // Booth datapath: shift has priority over add.
    always_ff @(posedge clk or posedge dp_rst) begin
        if (dp_rst) begin
            ra  <= '0;
            rq  <= '0;
            rm  <= '0;
            qm1 <= 1'b0;
            cnt <= '0;
        end else begin
            if (control[7]) begin
                {ra, rq, qm1} <= {ra[7], ra, rq};
                if (control[8])
                    cnt <= cnt + 3'd1;
            end else if (control[0]) begin
                ra <= control[4] ? ra - rm : ra + rm;
            end
            if (control[2]) rm <= inbus;
            if (control[1]) rq <= inbus;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic run_mul(
        input  logic [7:0] m,
        input  logic [7:0] q,
        output logic [7:0] hi,
        output logic [7:0] lo,
        output int         lat,
        output int         adds,
        output int         dones,
        output int         seq_ok,
        output int         timed_out
    );
        int seen;
        seen = -1;
        hi = 8'h00; lo = 8'h00;
        lat = -1; adds = 0; dones = 0;
        seq_ok = 1; timed_out = 1;
        mm = m; mq = q; out_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            if (c > 1) @(negedge clk);
            if (c == 1 && !(dp_clr && control == 11'h000)) seq_ok = 0;
            if (c == 2 && !(control == 11'h004 && !opnd_sel)) seq_ok = 0;
            if (c == 3 && !(control == 11'h002 && opnd_sel)) seq_ok = 0;
            if (control[0]) adds++;
            if (out_valid && lat < 0) lat = c;
            if (out_valid && out_ready) begin
                if (out_hi) hi = outbus;
                else        lo = outbus;
            end
            if (done) begin
                dones++;
                if (seen < 0) seen = c;
            end
            if (seen >= 0 && c >= seen + 2) begin
                timed_out = 0;
                break;
            end
        end
    endtask

    typedef struct {
        logic [7:0] m;
        logic [7:0] q;
        logic [7:0] hi;
        logic [7:0] lo;
        int         lat;
        int         adds;
    } vec_t;

    vec_t vecs[6];

    initial begin
        logic [7:0] hi, lo;
        int lat, adds, dones, seq_ok, to;
        int stable;
        int waited;

        vecs[0] = '{8'h03, 8'h05, 8'h00, 8'h0F, 16, 4};
        vecs[1] = '{8'h07, 8'hFF, 8'hFF, 8'hF9, 13, 1};
        vecs[2] = '{8'hFD, 8'h05, 8'hFF, 8'hF1, 16, 4};
        vecs[3] = '{8'h05, 8'h00, 8'h00, 8'h00, 12, 0};
        vecs[4] = '{8'h03, 8'h55, 8'h00, 8'hFF, 20, 8};
        vecs[5] = '{8'h02, 8'hFE, 8'hFF, 8'hFC, 13, 1};

        reset = 1'b1; start = 1'b0; out_ready = 1'b0;
        mm = 8'h00; mq = 8'h00;
        repeat (2) @(negedge clk);
        check("rst_outputs",
              {control, dp_clr, opnd_sel, busy, out_valid, out_hi, done}, 0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);

        for (int i = 0; i < 6; i++) begin
            run_mul(vecs[i].m, vecs[i].q, hi, lo, lat, adds, dones, seq_ok, to);
            check($sformatf("v%0d_timeout", i), to, 0);
            check($sformatf("v%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("v%0d_lo", i), lo, vecs[i].lo);
            check($sformatf("v%0d_latency", i), lat, vecs[i].lat);
            check($sformatf("v%0d_addcycles", i), adds, vecs[i].adds);
            check($sformatf("v%0d_done", i), dones, 1);
            check($sformatf("v%0d_setup_seq", i), seq_ok, 1);
        end

        // back-pressure in OUT_A, then a stray start in OUT_Q
        mm = 8'h03; mq = 8'h05; out_ready = 1'b0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        waited = 0;
        while (!out_valid && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check("bp_reach_outa", out_valid, 1);
        stable = 1;
        for (int k = 0; k < 5; k++) begin
            if (!(control == 11'h200 && out_hi && out_valid
                  && outbus == 8'h00))
                stable = 0;
            @(negedge clk);
        end
        check("bp_hold_outa", stable, 1);
        check("bp_still_outa", {control[9], out_hi}, 2'b11);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_outq_lo", {out_valid, out_hi, outbus}, {2'b10, 8'h0F});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("bp_start_ignored",
              {busy, out_valid, out_hi, control[10], dp_clr}, 5'b11010);
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_done_pulse", {done, busy}, 2'b10);
        @(negedge clk);
        check("bp_done_once", {done, busy, dp_clr}, 3'b000);

        // reset in cycle 7
        mm = 8'h03; mq = 8'h05;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (6) @(negedge clk);
        check("mid_busy_before", busy, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_outputs",
              {control, dp_clr, opnd_sel, busy, out_valid, out_hi, done}, 0);
        @(negedge clk);
        reset = 1'b0;
        run_mul(8'h02, 8'hFE, hi, lo, lat, adds, dones, seq_ok, to);
        check("post_rst_timeout", to, 0);
        check("post_rst_hi", hi, 8'hFF);
        check("post_rst_lo", lo, 8'hFC);
        check("post_rst_latency", lat, 13);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
